// File: rtl/bit_packer15_pkg.sv
// Shared constants for the bit packer.
//   DEF_WIDTH : default assembled word width
//   CNT_W     : width of the fill counter and of dout_count (holds 0..15)
//   SLICE_W   : bits accepted per serial transfer
package bit_packer15_pkg;
    localparam int DEF_WIDTH = 15;
    localparam int CNT_W     = 4;
    localparam int SLICE_W   = 1;
endpackage

// File: rtl/bit_packer15_count.sv
// packer_count: 0..WIDTH fill counter for the assembly register.
//   clk, rst  : clock, synchronous active-high reset
//   inc       : a bit was accepted this cycle
//   clr       : word leaves the assembly register this cycle (wins over inc)
//   count     : current fill level
//   count_nxt : fill level including this cycle's bit, before any clear
//   full      : count == WIDTH
module packer_count
    import bit_packer15_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_nxt,
    output logic             full
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);

    assign count_nxt = count + {{(CNT_W-1){1'b0}}, inc};
    assign full      = (count == FULL);

    always_ff @(posedge clk) begin
        if (rst || clr) count <= '0;
        else            count <= count_nxt;
    end
endmodule

// File: rtl/bit_packer15.sv
// bit_packer15: serial-to-parallel packer with flush and a decoupled output.
//   clk, rst    : clock, synchronous active-high reset
//   bit_in      : serial data bit, taken when bit_valid && bit_ready
//   bit_valid   : bit_in offered
//   bit_ready   : assembly register can take a bit (registered state only)
//   flush       : emit the partial word (bit of the same cycle included)
//   dout        : assembled word, unfilled positions zero
//   dout_count  : valid bits in dout
//   dout_valid  : dout/dout_count hold a word, taken when dout_ready is high
//   dout_ready  : consumer takes the word
//   busy        : assembly register non-empty or a word is waiting
// The assembly register is separate from the output register so filling
// continues while a word waits downstream.
module bit_packer15
    import bit_packer15_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] dout_count,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);

    logic [WIDTH-1:0] asm_q, asm_nxt;
    logic             pend_q;
    logic [CNT_W-1:0] cnt, cnt_nxt, pos;
    logic             full, bit_xfer, out_free, word_done, emit_req, load;

    // Full or a stuck flush both stall the serial side; neither depends
    // on dout_ready, so there is no combinational path to bit_ready.
    assign bit_ready = !full && !pend_q;
    assign bit_xfer  = bit_valid && bit_ready;
    assign out_free  = !dout_valid || dout_ready;
    assign busy      = (cnt != '0) || dout_valid;

    packer_count #(.WIDTH(WIDTH)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (bit_xfer),
        .clr       (load),
        .count     (cnt),
        .count_nxt (cnt_nxt),
        .full      (full)
    );

    assign pos = LSB_FIRST ? cnt : (FULL - 4'd1 - cnt);

    always_comb begin
        asm_nxt = asm_q;
        for (int i = 0; i < WIDTH; i++)
            if (bit_xfer && (pos == CNT_W'(i))) asm_nxt[i] = bit_in;
    end

    // The word (including this cycle's bit) leaves when it is complete, when
    // a stalled flush is pending, or on a flush with at least one bit.
    assign word_done = (cnt_nxt == FULL);
    assign emit_req  = word_done || pend_q || (flush && (cnt_nxt != '0));
    assign load      = emit_req && out_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q      <= '0;
            pend_q     <= 1'b0;
            dout       <= '0;
            dout_count <= '0;
            dout_valid <= 1'b0;
        end else if (load) begin
            asm_q      <= '0;
            pend_q     <= 1'b0;
            dout       <= asm_nxt;
            dout_count <= cnt_nxt;
            dout_valid <= 1'b1;
        end else begin
            asm_q  <= asm_nxt;
            // A complete word waits on its own via the full counter; only a
            // partial word needs the flag to remember the flush.
            pend_q <= emit_req && !word_done;
            if (dout_ready) dout_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bit_packer15.sv
module tb_bit_packer15;
    localparam int W = 15;

    logic clk = 1'b0;
    logic rst, bit_in, bit_valid, flush, dout_ready;
    logic [W-1:0] d0_dout, d1_dout;
    logic [3:0]   d0_cnt, d1_cnt;
    logic         d0_valid, d1_valid, d0_rdy, d1_rdy, d0_busy, d1_busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    bit_packer15 #(.WIDTH(W), .LSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(d0_rdy), .flush(flush), .dout(d0_dout), .dout_count(d0_cnt),
        .dout_valid(d0_valid), .dout_ready(dout_ready), .busy(d0_busy));

    bit_packer15 #(.WIDTH(W), .LSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(d1_rdy), .flush(flush), .dout(d1_dout), .dout_count(d1_cnt),
        .dout_valid(d1_valid), .dout_ready(dout_ready), .busy(d1_busy));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Current word is a queue of accepted bits; the output slot is a
    // (valid, word, count) triple. Both bit orders come from the same queue.
    int           mq[$];
    bit           m_pend = 1'b0, m_ov = 1'b0, m_rdy, m_free, m_emit;
    int           m_oc = 0;
    logic [W-1:0] m_od0 = '0, m_od1 = '0;

    function automatic logic [W-1:0] pack(input bit lsb);
        logic [W-1:0] w = '0;
        for (int i = 0; i < mq.size(); i++)
            if (mq[i] != 0) w[lsb ? i : W-1-i] = 1'b1;
        return w;
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_pend = 1'b0; m_ov = 1'b0; m_oc = 0; m_od0 = '0; m_od1 = '0;
        end else begin
            m_rdy  = (mq.size() != W) && !m_pend;
            m_free = !m_ov || dout_ready;
            if (bit_valid && m_rdy) mq.push_back(int'(bit_in));
            m_emit = (mq.size() == W) || m_pend || (flush && mq.size() > 0);
            if (m_emit && m_free) begin
                m_od0 = pack(1'b1); m_od1 = pack(1'b0);
                m_oc = mq.size(); m_ov = 1'b1; m_pend = 1'b0;
                mq.delete();
            end else begin
                if (m_emit) m_pend = (mq.size() != W);
                if (m_ov && dout_ready) m_ov = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("valid0", 32'(d0_valid), 32'(m_ov));
            chk("valid1", 32'(d1_valid), 32'(m_ov));
            chk("ready0", 32'(d0_rdy), 32'((mq.size() != W) && !m_pend));
            chk("ready1", 32'(d1_rdy), 32'((mq.size() != W) && !m_pend));
            chk("busy0",  32'(d0_busy), 32'((mq.size() > 0) || m_ov));
            chk("busy1",  32'(d1_busy), 32'((mq.size() > 0) || m_ov));
            if (m_ov) begin
                chk("dout0", 32'(d0_dout), 32'(m_od0));
                chk("dout1", 32'(d1_dout), 32'(m_od1));
                chk("cnt0",  32'(d0_cnt),  32'(m_oc));
                chk("cnt1",  32'(d1_cnt),  32'(m_oc));
            end
            if (d0_valid && dout_ready) n_out++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input logic b);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b1; bit_in = b; step();
        end
        bit_valid = 1'b0;
    endtask

    int n0;

    initial begin
        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; flush = 1'b0; dout_ready = 1'b1;
        step(); step();
        chk_en = 1'b1;
        chk("rst_dout", 32'(d0_dout), 32'h0);
        chk("rst_cnt", 32'(d0_cnt), 32'h0);
        chk("rst_valid", 32'(d0_valid), 32'h0);
        chk("rst_ready", 32'(d0_rdy), 32'h1);
        chk("rst_busy", 32'(d0_busy), 32'h0);
        rst = 1'b0;

        // alternating bits starting with 1: even positions set either order
        for (int i = 0; i < W; i++) begin
            bit_valid = 1'b1; bit_in = (i % 2 == 0); step();
        end
        bit_valid = 1'b0;
        chk("alt_valid", 32'(d0_valid), 32'h1);
        chk("alt_lsb", 32'(d0_dout), 32'h5555);
        chk("alt_msb", 32'(d1_dout), 32'h5555);
        chk("alt_cnt", 32'(d0_cnt), 32'd15);
        step();
        chk("alt_onecycle", 32'(d0_valid), 32'h0);

        // order-sensitive: first two bits 1
        send(2, 1'b1); send(13, 1'b0);
        chk("ord_lsb", 32'(d0_dout), 32'h0003);
        chk("ord_msb", 32'(d1_dout), 32'h6000);
        step();

        // backpressure: 30 ones with the consumer stalled
        dout_ready = 1'b0;
        send(30, 1'b1);
        chk("bp_word", 32'(d0_dout), 32'h7FFF);
        chk("bp_ready", 32'(d0_rdy), 32'h0);
        step(); step();
        chk("bp_stable", 32'(d0_dout), 32'h7FFF);
        chk("bp_vheld", 32'(d0_valid), 32'h1);
        n0 = n_out;
        dout_ready = 1'b1;
        step(); step(); step();
        chk("bp_two_words", 32'(n_out - n0), 32'd2);
        chk("bp_idle", 32'(d0_busy), 32'h0);

        // flush a 3-bit partial word
        send(3, 1'b1);
        flush = 1'b1; step(); flush = 1'b0;
        chk("fl_lsb", 32'(d0_dout), 32'h0007);
        chk("fl_msb", 32'(d1_dout), 32'h7000);
        chk("fl_cnt", 32'(d0_cnt), 32'd3);
        step();
        flush = 1'b1; step(); flush = 1'b0;
        chk("fl_empty", 32'(d0_valid), 32'h0);
        step();

        // reset mid-word discards the partial
        send(7, 1'b1);
        rst = 1'b1; step(); rst = 1'b0;
        n0 = n_out;
        chk("rmw_busy", 32'(d0_busy), 32'h0);
        send(1, 1'b1); send(14, 1'b0);
        chk("rmw_word", 32'(d0_dout), 32'h0001);
        chk("rmw_cnt", 32'(d0_cnt), 32'd15);
        step();
        chk("rmw_one_out", 32'(n_out - n0), 32'd1);

        // flush while the output register is full
        dout_ready = 1'b0;
        send(15, 1'b1);
        send(3, 1'b1);
        flush = 1'b1; step(); flush = 1'b0;
        chk("pf_ready", 32'(d0_rdy), 32'h0);
        step(); step();
        chk("pf_hold", 32'(d0_rdy), 32'h0);
        dout_ready = 1'b1; step();
        chk("pf_valid", 32'(d0_valid), 32'h1);
        chk("pf_cnt", 32'(d0_cnt), 32'd3);
        chk("pf_word", 32'(d0_dout), 32'h0007);
        step();
        chk("pf_ready_back", 32'(d0_rdy), 32'h1);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bit_valid  = ($urandom_range(0, 3) != 0);
            bit_in     = 1'($urandom_range(0, 1));
            flush      = ($urandom_range(0, 11) == 0);
            dout_ready = ($urandom_range(0, 2) != 0);
            rst        = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; bit_valid = 1'b0; flush = 1'b0; dout_ready = 1'b1;
        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
